// File: rtl/arithmetic_decoder_static.sv
// Static-model arithmetic decoder.
// Decodes a bit stream produced by the matching encoder using a fixed uniform model over
// DECODER_NUM_OF_SYMBOLS symbols (freqBegin[s]=s, freqEnd[s]=s+1). Every division goes through
// one shared serial restoring divider (one quotient bit per cycle).
// Ports:
//   clk, rstn        clock (rising edge) and asynchronous active-low reset
//   start            begin decoding; the first stream word is on inputBits
//   newBitsProvided  host has placed the next stream word on inputBits
//   inputBits        32-bit stream word, bit 0 is the earliest bit
//   readSuccess      host has read out
//   idle             decoder is idle
//   newBitsRequested next stream word is requested
//   resultReady      out holds a decoded symbol
//   eof              end-of-stream symbol decoded, held until the next start
//   out              decoded symbol
module arithmetic_decoder_static #(
  parameter int unsigned DECODER_PRECISION      = 16,
  parameter int unsigned DECODER_NUM_OF_SYMBOLS = 257,
  parameter int unsigned DECODER_EOF_SYMBOL     = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        newBitsProvided,
  input  logic [31:0] inputBits,
  input  logic        readSuccess,
  output logic        idle,
  output logic        newBitsRequested,
  output logic        resultReady,
  output logic        eof,
  output logic [7:0]  out
);
  localparam int unsigned P  = DECODER_PRECISION;
  localparam int unsigned DW = 24;
  localparam int unsigned SW = $clog2(DECODER_NUM_OF_SYMBOLS);

  localparam logic [P-1:0]  WHOLE     = {1'b1, {(P-1){1'b0}}};
  localparam logic [P-1:0]  HALF      = {2'b01, {(P-2){1'b0}}};
  localparam logic [P-1:0]  QUARTER   = {3'b001, {(P-3){1'b0}}};
  localparam logic [P-1:0]  THREEQ    = {3'b011, {(P-3){1'b0}}};
  localparam logic [P-1:0]  TOTAL     = P'(DECODER_NUM_OF_SYMBOLS);
  localparam logic [SW-1:0] EOF_SYM   = SW'(DECODER_EOF_SYMBOL);
  localparam logic [4:0]    LOAD_LAST = 5'(P - 2);
  localparam logic [4:0]    DIV_LAST  = 5'(DW - 1);

  typedef enum logic [3:0] {
    StIdle, StLoadCode, StFindSymbol, StDivide, StNewSubinterval, StScale,
    StWaitForReadAck, StReadAcknowledged, StWaitForNewBits, StNewBitsProvided
  } state_e;

  // Which of the three per-symbol divisions the divider is running.
  typedef enum logic [1:0] {PhSym, PhHigh, PhLow} phase_e;

  state_e        state_q, state_d, ret_q, ret_d;
  phase_e        phase_q, phase_d;
  logic [P-1:0]  a_q, a_d, b_q, b_d, w_q, w_d, z_q, z_d, hi_q, hi_d;
  logic [SW-1:0] sym_q, sym_d;
  logic [31:0]   word_q, word_d;
  logic [5:0]    ptr_q, ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [P-1:0]  dvs_q, dvs_d, rem_q, rem_d;
  logic          eof_q, eof_d;
  logic [7:0]    out_q, out_d;

  // Divider datapath: dvd_q shifts the dividend out at the top and the quotient in at the bottom.
  logic [P:0]    rem_shift, rem_sub, rem_next;
  logic          q_bit;
  logic [DW-1:0] dvd_next;
  logic [SW-1:0] sym_clamp;

  always_comb begin
    rem_shift = {rem_q, dvd_q[DW-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_next  = q_bit ? rem_sub : rem_shift;
    dvd_next  = {dvd_q[DW-2:0], q_bit};
    sym_clamp = (dvd_next > DW'(EOF_SYM)) ? EOF_SYM : dvd_next[SW-1:0];
  end

  logic          cur_bit;
  logic          scale_go;
  logic [P-1:0]  scale_off, a_sub, b_sub, z_sub;
  logic [DW-1:0] find_dvd;

  assign cur_bit  = word_q[ptr_q[4:0]];
  assign find_dvd = (DW'(z_q - a_q) + DW'(1)) * DW'(TOTAL) - DW'(1);

  always_comb begin
    scale_go  = 1'b1;
    scale_off = '0;
    if (b_q < HALF) begin
      scale_off = '0;
    end else if (a_q > HALF) begin
      scale_off = HALF;
    end else if ((a_q > QUARTER) && (b_q < THREEQ)) begin
      scale_off = QUARTER;
    end else begin
      scale_go = 1'b0;
    end
    a_sub = a_q - scale_off;
    b_sub = b_q - scale_off;
    z_sub = z_q - scale_off;
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    phase_d = phase_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    z_d     = z_q;
    hi_d    = hi_q;
    sym_d   = sym_q;
    word_d  = word_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    eof_d   = eof_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          word_d  = inputBits;
          a_d     = '0;
          b_d     = WHOLE;
          w_d     = WHOLE;
          z_d     = '0;
          ptr_d   = '0;
          cnt_d   = '0;
          eof_d   = 1'b0;
          state_d = StLoadCode;
        end
      end
      StLoadCode: begin
        if (ptr_q[5]) begin
          ret_d   = StLoadCode;
          state_d = StWaitForNewBits;
        end else begin
          z_d   = {z_q[P-2:0], cur_bit};
          ptr_d = ptr_q + 6'd1;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LOAD_LAST) state_d = StFindSymbol;
        end
      end
      StFindSymbol: begin
        dvd_d   = find_dvd;
        dvs_d   = w_q;
        rem_d   = '0;
        cnt_d   = '0;
        phase_d = PhSym;
        state_d = StDivide;
      end
      StDivide: begin
        dvd_d = dvd_next;
        rem_d = rem_next[P-1:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          rem_d = '0;
          dvs_d = TOTAL;
          unique case (phase_q)
            PhSym: begin
              sym_d   = sym_clamp;
              dvd_d   = DW'(w_q) * DW'(sym_clamp) + DW'(w_q);
              phase_d = PhHigh;
            end
            PhHigh: begin
              hi_d    = dvd_next[P-1:0];
              dvd_d   = DW'(w_q) * DW'(sym_q);
              phase_d = PhLow;
            end
            default: begin
              // Low quotient stays in dvd_q for the next state.
              state_d = StNewSubinterval;
            end
          endcase
        end
      end
      StNewSubinterval: begin
        b_d     = a_q + hi_q;
        a_d     = a_q + dvd_q[P-1:0];
        state_d = StScale;
      end
      StScale: begin
        if (scale_go) begin
          // Fetch lazily: the request only goes out once a bit is actually needed.
          if (ptr_q[5]) begin
            ret_d   = StScale;
            state_d = StWaitForNewBits;
          end else begin
            a_d   = {a_sub[P-2:0], 1'b0};
            b_d   = {b_sub[P-2:0], 1'b0};
            z_d   = {z_sub[P-2:0], cur_bit};
            ptr_d = ptr_q + 6'd1;
          end
        end else begin
          w_d = b_q - a_q;
          if (sym_q == EOF_SYM) begin
            eof_d   = 1'b1;
            state_d = StIdle;
          end else begin
            out_d   = sym_q[7:0];
            state_d = StWaitForReadAck;
          end
        end
      end
      StWaitForReadAck: begin
        if (readSuccess) state_d = StReadAcknowledged;
      end
      StReadAcknowledged: begin
        if (!readSuccess) state_d = StFindSymbol;
      end
      StWaitForNewBits: begin
        if (newBitsProvided) begin
          word_d  = inputBits;
          ptr_d   = '0;
          state_d = StNewBitsProvided;
        end
      end
      StNewBitsProvided: begin
        if (!newBitsProvided) state_d = ret_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      ret_q   <= StIdle;
      phase_q <= PhSym;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      sym_q   <= '0;
      word_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      eof_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      phase_q <= phase_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      sym_q   <= sym_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      eof_q   <= eof_d;
      out_q   <= out_d;
    end
  end

  assign idle             = (state_q == StIdle);
  assign resultReady      = (state_q == StWaitForReadAck);
  assign newBitsRequested = (state_q == StWaitForNewBits);
  assign eof              = eof_q;
  assign out              = out_q;

endmodule

// File: tb/tb_arithmetic_decoder_static.sv
// Bench for arithmetic_decoder_static: an integer-arithmetic encoder builds streams from symbol
// lists, a reference decoder gives the bit position reached after each symbol, and a host
// loop services both four-phase handshakes while checking every result.
module tb_arithmetic_decoder_static;
  localparam int WHOLE   = 32768;
  localparam int HALF    = 16384;
  localparam int QTR     = 8192;
  localparam int TQTR    = 24576;
  localparam int TOTAL   = 257;
  localparam int EOF_SYM = 256;
  localparam int BUDGET  = 8000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        newBitsProvided;
  logic [31:0] inputBits;
  logic        readSuccess;
  logic        idle;
  logic        newBitsRequested;
  logic        resultReady;
  logic        eof;
  logic [7:0]  out;

  arithmetic_decoder_static dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .newBitsProvided  (newBitsProvided),
    .inputBits        (inputBits),
    .readSuccess      (readSuccess),
    .idle             (idle),
    .newBitsRequested (newBitsRequested),
    .resultReady      (resultReady),
    .eof              (eof),
    .out              (out)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] words[$];
  int          exp_syms[$];
  int          m_cum[$];
  bit          enc_bits[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic emit_with_pending(input bit b, input int pend);
    enc_bits.push_back(b);
    for (int i = 0; i < pend; i++) enc_bits.push_back(!b);
  endtask

  // Encoder: exp_syms -> words (bit 0 of each word first).
  task automatic encode_syms();
    int low, high, w, pend;
    logic [31:0] wd;
    low = 0; high = WHOLE; pend = 0;
    enc_bits.delete();
    foreach (exp_syms[n]) begin
      w    = high - low;
      high = low + (w * (exp_syms[n] + 1)) / TOTAL;
      low  = low + (w * exp_syms[n]) / TOTAL;
      for (int g = 0; g < 64; g++) begin
        if (high < HALF) begin
          emit_with_pending(1'b0, pend); pend = 0;
        end else if (low > HALF) begin
          emit_with_pending(1'b1, pend); pend = 0; low -= HALF; high -= HALF;
        end else if (low > QTR && high < TQTR) begin
          pend++; low -= QTR; high -= QTR;
        end else break;
        low  = 2 * low;
        high = 2 * high;
      end
    end
    pend++;
    if (low <= QTR) emit_with_pending(1'b0, pend);
    else emit_with_pending(1'b1, pend);
    words.delete();
    for (int i = 0; i < enc_bits.size(); i += 32) begin
      wd = '0;
      for (int j = 0; j < 32; j++) if (i + j < enc_bits.size()) wd[j] = enc_bits[i + j];
      words.push_back(wd);
    end
  endtask

  function automatic int get_bit(input int pos);
    if (pos / 32 < words.size()) return int'(words[pos / 32][pos % 32]);
    return 0;
  endfunction

  // Reference decoder over words (zeros past the end): m_cum[k] = bits consumed after symbol k.
  task automatic model_decode();
    int a, b, w, z, pos, s, off;
    m_cum.delete();
    a = 0; b = WHOLE; w = WHOLE; z = 0;
    for (int i = 0; i < 15; i++) z = 2 * z + get_bit(i);
    pos = 15;
    for (int n = 0; n < 1000; n++) begin
      s = ((z - a + 1) * TOTAL - 1) / w;
      if (s > EOF_SYM) s = EOF_SYM;
      b = a + (w * (s + 1)) / TOTAL;
      a = a + (w * s) / TOTAL;
      for (int g = 0; g < 64; g++) begin
        if (b < HALF) off = 0;
        else if (a > HALF) off = HALF;
        else if (a > QTR && b < TQTR) off = QTR;
        else break;
        a   = 2 * (a - off);
        b   = 2 * (b - off);
        z   = 2 * (z - off) + get_bit(pos);
        pos++;
      end
      w = b - a;
      m_cum.push_back(pos);
      if (s == EOF_SYM) break;
    end
  endtask

  // Runs one stream from posedge+1. bp_idx: hold off the ack of that result for 100 cycles.
  // hh_idx: keep readSuccess high for 200 cycles after that result's ack. junk_idx: drive
  // start/newBitsProvided with random data while that result is pending.
  task automatic run_stream(input string name, input int bp_idx, input int hh_idx,
                            input int junk_idx);
    int widx, ridx, cyc, k, bad, n_req, exp_req;
    bit done, pend_nb, pend_rs;
    start = 1'b1; inputBits = words[0]; widx = 1;
    @(posedge clk); #1;
    start = 1'b0; inputBits = '0;
    ridx = 0; cyc = 0; n_req = 0; done = 0; pend_nb = 0; pend_rs = 0;
    while (!done && cyc < BUDGET) begin
      if (eof) begin
        check_eq({name, "_eof_count"}, ridx, exp_syms.size() - 1);
        check_eq({name, "_eof_idle"}, int'(idle), 1);
        check_eq({name, "_eof_rr"}, int'(resultReady), 0);
        done = 1;
      end else begin
        if (newBitsRequested && !pend_nb) begin
          k = 0;
          while (k < m_cum.size() - 1 && m_cum[k] <= 32 * widx) k++;
          check_eq({name, "_req_sym"}, ridx, k);
          n_req++;
          inputBits = (widx < words.size()) ? words[widx] : 32'h0;
          newBitsProvided = 1'b1;
          pend_nb = 1;
        end else if (pend_nb && !newBitsRequested) begin
          newBitsProvided = 1'b0; inputBits = '0; widx++; pend_nb = 0;
        end
        if (resultReady && !pend_rs) begin
          check_eq({name, "_out"}, int'(out), (ridx < exp_syms.size()) ? exp_syms[ridx] : -1);
          if (ridx == junk_idx) begin
            for (int i = 0; i < 3; i++) begin
              start = 1'b1; newBitsProvided = 1'b1; inputBits = $urandom;
              @(posedge clk); #1;
            end
            start = 1'b0; newBitsProvided = 1'b0; inputBits = '0;
            check_eq({name, "_junk_rr"}, int'(resultReady), 1);
          end
          if (ridx == bp_idx) begin
            bad = 0;
            for (int i = 0; i < 100; i++) begin
              @(posedge clk); #1;
              if (!resultReady || int'(out) != exp_syms[ridx] || newBitsRequested) bad++;
            end
            check_eq({name, "_bp_stable"}, bad, 0);
          end
          readSuccess = 1'b1;
          pend_rs = 1;
        end else if (pend_rs && !resultReady) begin
          if (ridx == hh_idx) begin
            bad = 0;
            for (int i = 0; i < 200; i++) begin
              @(posedge clk); #1;
              if (resultReady || eof) bad++;
            end
            check_eq({name, "_withheld"}, bad, 0);
          end
          readSuccess = 1'b0; pend_rs = 0; ridx++;
        end
      end
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_eq({name, "_finished"}, int'(done), 1);
    exp_req = (m_cum[m_cum.size() - 1] - 1) / 32;
    check_eq({name, "_req_count"}, n_req, exp_req);
    readSuccess = 1'b0; newBitsProvided = 1'b0; inputBits = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq({name, "_eof_hold"}, int'(eof), 1);
  endtask

  initial begin
    int cyc;
    bit got;
    rstn = 1'b0; start = 1'b0; newBitsProvided = 1'b0; inputBits = '0; readSuccess = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_idle", int'(idle), 1);
    check_eq("rst_rr", int'(resultReady), 0);
    check_eq("rst_req", int'(newBitsRequested), 0);
    check_eq("rst_eof", int'(eof), 0);
    check_eq("rst_out", int'(out), 0);
    rstn = 1'b1;

    // EOF-only stream: eight ones give z=0x7F80, which decodes to the end symbol.
    words = {32'h000000FF};
    exp_syms = {EOF_SYM};
    model_decode();
    run_stream("eofonly", -1, -1, -1);

    exp_syms = {8'h41, 8'h00, 8'hFF, EOF_SYM};
    encode_syms();
    model_decode();
    run_stream("roundtrip", -1, -1, -1);

    // Reset in the middle of the second symbol's divide.
    @(posedge clk); #1;
    start = 1'b1; inputBits = words[0];
    @(posedge clk); #1;
    start = 1'b0; inputBits = '0;
    got = 0;
    for (cyc = 0; cyc < 500 && !got; cyc++) begin
      @(posedge clk); #1;
      if (resultReady) got = 1;
    end
    check_eq("rstdiv_first", got ? int'(out) : -1, 8'h41);
    readSuccess = 1'b1;
    @(posedge clk); #1;
    readSuccess = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_eq("rstdiv_idle", int'(idle), 1);
    check_eq("rstdiv_rr", int'(resultReady), 0);
    check_eq("rstdiv_req", int'(newBitsRequested), 0);
    check_eq("rstdiv_eof", int'(eof), 0);
    check_eq("rstdiv_out", int'(out), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    words = {32'h000000FF};
    exp_syms = {EOF_SYM};
    model_decode();
    run_stream("after_rst", -1, -1, -1);

    // Long stream crossing several word boundaries, with backpressure and stray inputs.
    exp_syms.delete();
    repeat (39) exp_syms.push_back(int'($urandom_range(255, 0)));
    exp_syms.push_back(EOF_SYM);
    encode_syms();
    model_decode();
    run_stream("wordbound", 5, 8, 2);

    exp_syms.delete();
    repeat (15) exp_syms.push_back(int'($urandom_range(255, 0)));
    exp_syms.push_back(EOF_SYM);
    encode_syms();
    model_decode();
    run_stream("random", -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arithmetic_decoder_static.md
ARITHMETIC_DECODER_STATIC -- requirements
Module: arithmetic_decoder_static

Interface
REQ-001 SHALL have parameters: DECODER_PRECISION default 16, interval precision; DECODER_NUM_OF_SYMBOLS default 257, alphabet size; DECODER_EOF_SYMBOL default 256, end-of-stream symbol.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  begin decoding; first stream word is on inputBits.
- newBitsProvided  in  1  host has placed the next stream word on inputBits.
- inputBits  in  32  encoded stream word; bit 0 is the earliest bit.
- readSuccess  in  1  host has read the out value.
- idle  out  1  decoder is in IDLE.
- newBitsRequested  out  1  next stream word is requested.
- resultReady  out  1  out holds a decoded symbol.
- eof  out  1  EOF decoded; stream finished.
- out  out  8  decoded symbol.

Function
REQ-003 SHALL use a fixed uniform model: freqBegin[s]=s, freqEnd[s]=s+1, total=257; WHOLE=2^15, HALF=2^14, QUARTER=2^13, THREEQ=3*2^13.
REQ-004 SHALL use these states: IDLE, LOAD_CODE, FIND_SYMBOL, DIVIDE, NEW_SUBINTERVAL, SCALE, WAIT_FOR_READ_ACK, READ_ACKNOWLEDGED, WAIT_FOR_NEW_BITS, NEW_BITS_PROVIDED.
REQ-005 On start=1 in IDLE, the block SHALL latch inputBits, set a=0, b=WHOLE, w=WHOLE, clear the bit pointer, and go to LOAD_CODE.
REQ-006 LOAD_CODE SHALL shift 15 stream bits into code z, MSB-first, one bit per cycle.
REQ-007 In FIND_SYMBOL, the value SHALL be floor(((z-a+1)*257-1)/w), clamped to 256, and this value is the symbol.
REQ-008 The new interval SHALL be b'=a+floor(w*(sym+1)/257) and a'=a+floor(w*sym/257), computed with the same floor division the encoder uses.
REQ-009 All divisions SHALL use one internal serial restoring divider: 24-bit dividend, 16-bit divisor, one quotient bit per cycle, 24 cycles per divide, no external IP.
REQ-010 SCALE SHALL mirror the encoder comparisons exactly, including strictness:
- if b<HALF: a=2a, b=2b.
- else if a>HALF: a=2(a-HALF), b=2(b-HALF).
- else if a>QUARTER and b<THREEQ: a=2(a-QUARTER), b=2(b-QUARTER).
- else: scaling ends.
- On every shift, z SHALL become 2z-offset plus the next stream bit.
REQ-011 When scaling ends, the block SHALL set w=b-a and then:
- non-EOF symbol: assert resultReady with out=sym[7:0].
- EOF symbol: go to IDLE with eof=1; resultReady SHALL stay 0.
REQ-012 Result handshake:
- resultReady stays 1 until readSuccess=1.
- The block then drops resultReady and waits for readSuccess=0.
- It then goes to FIND_SYMBOL.
REQ-013 Input handshake:
- When all 32 bits of the current word are consumed and a further bit is needed, the block asserts newBitsRequested.
- On newBitsProvided=1 it latches inputBits, drops the request, and waits for newBitsProvided=0.
- It then resumes the interrupted state.
REQ-014 Bits requested past the stream end SHALL be whatever the host supplies; the host supplies 0 words.
REQ-015 eof SHALL stay 1 until the next start; start SHALL be ignored outside IDLE.
REQ-016 If readSuccess=1 and newBitsProvided=1 arrive while the matching request is not pending, the block SHALL ignore them.

Reset
REQ-017 When rstn=0, asynchronously: idle=1, resultReady=0, newBitsRequested=0, eof=0, out=0, state=IDLE, divider cleared.
REQ-018 Reset asserted mid-divide or mid-handshake SHALL abort the operation with no residual request or result.
REQ-019 After reset release, the block SHALL accept start on the next rising edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- EOF-only stream: start with inputBits=0x000000FF -> z=0x7F80, value 256, eof=1, idle=1, no resultReady, no newBitsRequested.
- Round trip: symbols 0x41,0x00,0xFF,EOF through the arithmetic_encoder model, words fed in order -> out 0x41,0x00,0xFF in order, then eof=1.
- Word boundary: 40-symbol round-trip stream -> newBitsRequested rises exactly when bit 32 is needed, and decode resumes correctly after the four-phase handshake.
- Backpressure: readSuccess held 0 for 100 cycles -> resultReady and out stay stable; no extra bits consumed.
- Reset during DIVIDE: rstn=0 for 1 cycle -> all outputs at reset values; a fresh start decodes the EOF-only stream correctly.
- readSuccess held 1 across the ack -> the next result is withheld until readSuccess=0.
